// File: rtl/req_encoder_pkg.sv
// Shared constants, FSM state type and helper for the sequential 8:3 request encoder.
package req_encoder_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {IDLE, PRESENT} enc_state_t;

    // True when more than one bit of v is set (clearing the lowest set bit leaves something).
    function automatic logic multi_hot(input logic [N-1:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

endpackage

// File: rtl/pri_enc_8_3.sv
// Combinational fixed-priority 8:3 encoder; bit 0 has the highest priority.
module pri_enc_8_3
    import req_encoder_pkg::*;
(
    input  logic [N-1:0]     in,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the lowest priority upward so the lowest set bit is assigned last.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |in;

endmodule

// File: rtl/req_encoder.sv
// Sequential 8:3 request encoder: sticky pending bits, encoded grant with valid/ack handshake.
// Build option: define REQ_ENCODER_ROUND_ROBIN_EN for rotating priority (default: fixed, bit 0 first).
module req_encoder
    import req_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N-1:0]     req,
    input  logic             ack,
    output logic [IDX_W-1:0] idx,
    output logic             valid,
    output logic [N-1:0]     pending,
    output logic             multi
);

    enc_state_t       state_q;
    logic [N-1:0]     pending_q;
    logic [N-1:0]     pending_d;
    logic [N-1:0]     clr;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic             multi_q;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic [IDX_W-1:0] grant_idx;

    // Clear the granted bit on an accepted handshake; a same-cycle new request wins.
    always_comb begin
        clr = '0;
        if (valid_q && ack) begin
            clr[idx_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | ({N{enable}} & req);
    end

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q;
    logic [N-1:0]     rotated;

    // Rotate so rr_ptr lands on bit 0, encode, then shift the result back (3-bit add wraps).
    always_comb begin
        rotated   = N'({pending_q, pending_q} >> rr_ptr_q);
        grant_idx = enc_idx + rr_ptr_q;
    end

    pri_enc_8_3 u_pri_enc (
        .in  (rotated),
        .idx (enc_idx),
        .any (enc_any)
    );
`else
    pri_enc_8_3 u_pri_enc (
        .in  (pending_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign grant_idx = enc_idx;
`endif

    // Pending capture plus the IDLE/PRESENT handshake FSM; every output is registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            multi_q   <= 1'b0;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
            rr_ptr_q  <= '0;
`endif
        end else begin
            pending_q <= pending_d;
            multi_q   <= multi_hot(pending_d);
            unique case (state_q)
                IDLE: begin
                    if (enc_any) begin
                        idx_q   <= grant_idx;
                        valid_q <= 1'b1;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    // idx stays frozen until the consumer accepts it.
                    if (ack) begin
                        valid_q  <= 1'b0;
                        state_q  <= IDLE;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
                        rr_ptr_q <= idx_q + 3'd1;
`endif
                    end
                end
            endcase
        end
    end

    assign idx     = idx_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign multi   = multi_q;

endmodule

// File: tb/tb_req_encoder.sv
// Self-checking bench for req_encoder: directed scenarios plus randomized traffic vs. a model.
module tb_req_encoder;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] req;
    logic       ack;
    logic [2:0] idx;
    logic       valid;
    logic [7:0] pending;
    logic       multi;

    int n_checks = 0;
    int n_pass   = 0;

    req_encoder dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .req     (req),
        .ack     (ack),
        .idx     (idx),
        .valid   (valid),
        .pending (pending),
        .multi   (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a set of waiting requests and the one currently offered.
    logic [7:0] m_pend;
    logic       m_valid;
    logic [2:0] m_idx;
    logic [2:0] m_rr;
    logic [7:0] m_tmp;

    // Search positions in priority order starting at the pointer (0 in fixed mode).
    function automatic logic [2:0] pick(input logic [7:0] p, input logic [2:0] start);
        for (int k = 0; k < 8; k++) begin
            int pos;
            pos = (int'(start) + k) % 8;
            if (p[pos]) return 3'(pos);
        end
        return 3'd0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend  <= 8'h00;
            m_valid <= 1'b0;
            m_idx   <= 3'd0;
            m_rr    <= 3'd0;
        end else begin
            m_tmp = m_pend;
            if (m_valid && ack) m_tmp[m_idx] = 1'b0;
            if (enable) m_tmp = m_tmp | req;
            m_pend <= m_tmp;
            if (!m_valid) begin
                if (m_pend != 8'h00) begin
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
                    m_idx <= pick(m_pend, m_rr);
`else
                    m_idx <= pick(m_pend, 3'd0);
`endif
                    m_valid <= 1'b1;
                end
            end else if (ack) begin
                m_valid <= 1'b0;
                m_rr    <= 3'((int'(m_idx) + 1) % 8);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        req    = 8'h00;
        ack    = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++;
            if (valid !== 1'b0 || idx !== 3'd0 || pending !== 8'h00 || multi !== 1'b0)
                $display("FAIL reset_idle c%0d: got v=%b i=%0d p=%h m=%b required v=0 i=0 p=00 m=0",
                         c, valid, idx, pending, multi);
            else n_pass++;
        end
        enable = 1'b1;
        req    = 8'h02;
        step();
        req = 8'h00;
        step();
        n_checks++;
        if (valid !== 1'b1) $display("FAIL reset_pre_valid: got %b required 1", valid);
        else n_pass++;
        // Async assert between clock edges must drop valid immediately.
        reset = 1'b1;
        #1;
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h00)
            $display("FAIL reset_async: got v=%b p=%h required v=0 p=00", valid, pending);
        else n_pass++;
        step();
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        enable = 1'b1;
        req    = 8'h20;
        step();
        req = 8'h00;
        n_checks++;
        if (pending !== 8'h20 || valid !== 1'b0)
            $display("FAIL single_capture: got p=%h v=%b required p=20 v=0", pending, valid);
        else n_pass++;
        step();
        n_checks++;
        if (valid !== 1'b1 || idx !== 3'd5 || multi !== 1'b0)
            $display("FAIL single_grant: got v=%b i=%0d m=%b required v=1 i=5 m=0", valid, idx, multi);
        else n_pass++;
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++;
        if (pending !== 8'h00 || valid !== 1'b0)
            $display("FAIL single_ack: got p=%h v=%b required p=00 v=0", pending, valid);
        else n_pass++;
    endtask

    task automatic test_priority_hold();
        logic [2:0] exp_a;
        logic [2:0] exp_b;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
        exp_a = 3'd7;
        exp_b = 3'd0;
`else
        exp_a = 3'd0;
        exp_b = 3'd7;
`endif
        do_reset();
        enable = 1'b1;
        req    = 8'h90;
        step();
        req = 8'h00;
        step();
        n_checks++;
        if (valid !== 1'b1 || idx !== 3'd4 || multi !== 1'b1)
            $display("FAIL prio_grant: got v=%b i=%0d m=%b required v=1 i=4 m=1", valid, idx, multi);
        else n_pass++;
        req = 8'h01;
        step();
        req = 8'h00;
        step();
        n_checks++;
        if (valid !== 1'b1 || idx !== 3'd4 || pending !== 8'h91)
            $display("FAIL prio_hold: got v=%b i=%0d p=%h required v=1 i=4 p=91", valid, idx, pending);
        else n_pass++;
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h81)
            $display("FAIL prio_gap: got v=%b p=%h required v=0 p=81", valid, pending);
        else n_pass++;
        step();
        n_checks++;
        if (valid !== 1'b1 || idx !== exp_a)
            $display("FAIL prio_second: got v=%b i=%0d required v=1 i=%0d", valid, idx, exp_a);
        else n_pass++;
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        n_checks++;
        if (valid !== 1'b1 || idx !== exp_b || multi !== 1'b0)
            $display("FAIL prio_third: got v=%b i=%0d m=%b required v=1 i=%0d m=0",
                     valid, idx, multi, exp_b);
        else n_pass++;
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic test_set_wins();
        do_reset();
        enable = 1'b1;
        req    = 8'h08;
        step();
        req = 8'h00;
        step();
        n_checks++;
        if (valid !== 1'b1 || idx !== 3'd3)
            $display("FAIL setwins_grant: got v=%b i=%0d required v=1 i=3", valid, idx);
        else n_pass++;
        ack = 1'b1;
        req = 8'h08;
        step();
        ack = 1'b0;
        req = 8'h00;
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h08)
            $display("FAIL setwins_keep: got v=%b p=%h required v=0 p=08", valid, pending);
        else n_pass++;
        step();
        n_checks++;
        if (valid !== 1'b1 || idx !== 3'd3)
            $display("FAIL setwins_regrant: got v=%b i=%0d required v=1 i=3", valid, idx);
        else n_pass++;
    endtask

    task automatic test_enable_gating();
        do_reset();
        enable = 1'b0;
        req    = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (pending !== 8'h00 || valid !== 1'b0)
                $display("FAIL gate_block c%0d: got p=%h v=%b required p=00 v=0", c, pending, valid);
            else n_pass++;
        end
        enable = 1'b1;
        req    = 8'h02;
        step();
        enable = 1'b0;
        req    = 8'hFF;
        step();
        n_checks++;
        if (valid !== 1'b1 || idx !== 3'd1 || pending !== 8'h02)
            $display("FAIL gate_grant: got v=%b i=%0d p=%h required v=1 i=1 p=02", valid, idx, pending);
        else n_pass++;
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h00)
            $display("FAIL gate_ack: got v=%b p=%h required v=0 p=00", valid, pending);
        else n_pass++;
        req = 8'h00;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            enable = ($urandom_range(0, 3) != 0);
            req    = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            ack    = 1'($urandom_range(0, 1));
            step();
            n_checks++;
            if (valid !== m_valid || pending !== m_pend || multi !== ($countones(m_pend) > 1) ||
                (m_valid && idx !== m_idx))
                $display("FAIL random c%0d: got v=%b i=%0d p=%h m=%b required v=%b i=%0d p=%h",
                         c, valid, idx, pending, multi, m_valid, m_idx, m_pend);
            else n_pass++;
        end
        enable = 1'b0;
        req    = 8'h00;
        ack    = 1'b0;
    endtask

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    task automatic test_round_robin();
        logic [2:0] exp_seq [4];
        int         got;
        exp_seq = '{3'd0, 3'd7, 3'd0, 3'd7};
        got     = 0;
        do_reset();
        enable = 1'b1;
        req    = 8'h81;
        ack    = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            step();
            if (valid === 1'b1) begin
                n_checks++;
                if (idx !== exp_seq[got])
                    $display("FAIL rr_seq g%0d: got i=%0d required i=%0d", got, idx, exp_seq[got]);
                else n_pass++;
                got++;
            end
        end
        n_checks++;
        if (got != 4) $display("FAIL rr_timeout: got %0d grants required 4", got);
        else n_pass++;
        enable = 1'b0;
        req    = 8'h00;
        ack    = 1'b0;
    endtask
`endif

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        req    = 8'h00;
        ack    = 1'b0;
        test_reset();
        test_single();
        test_priority_hold();
        test_set_wins();
        test_enable_gating();
        test_random();
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
        test_round_robin();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
